// File: rtl/stencil_boundary_pipe.sv
// Boundary-substitution stage for the 2D hotspot stencil: tracks cell position,
// patches out-of-grid neighbours and registers the tuple with frame markers.
module stencil_boundary_pipe #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ROWS         = 512,
  parameter int                    COLS         = 512,
  parameter int                    BORDER_MODE  = 0,
  parameter logic [DATA_WIDTH-1:0] BORDER_CONST = '0,
  parameter int                    FRAME_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [5*DATA_WIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [5*DATA_WIDTH-1:0] m_data,
  output logic                    m_first,
  output logic                    m_last,
  output logic [FRAME_CNT_W-1:0]  frame_count
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic                  accept;
  logic                  at_top, at_bottom, at_left, at_right;
  logic [DATA_WIDTH-1:0] in_center, in_north, in_south, in_east, in_west;
  logic [DATA_WIDTH-1:0] sub_val, out_north, out_south, out_east, out_west;

  assign s_ready = rst_n & ~clear & (~m_valid | m_ready);
  assign accept  = s_valid & s_ready;

  assign in_center = s_data[5*DATA_WIDTH-1 -: DATA_WIDTH];
  assign in_north  = s_data[4*DATA_WIDTH-1 -: DATA_WIDTH];
  assign in_south  = s_data[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign in_east   = s_data[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign in_west   = s_data[DATA_WIDTH-1 -: DATA_WIDTH];

  assign at_top    = (row == '0);
  assign at_bottom = (row == ROW_LAST);
  assign at_left   = (col == '0);
  assign at_right  = (col == COL_LAST);

  // Missing neighbours take either the cell's own value or a fixed pad value.
  assign sub_val   = (BORDER_MODE != 0) ? BORDER_CONST : in_center;
  assign out_north = at_top    ? sub_val : in_north;
  assign out_south = at_bottom ? sub_val : in_south;
  assign out_east  = at_right  ? sub_val : in_east;
  assign out_west  = at_left   ? sub_val : in_west;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row         <= '0;
      col         <= '0;
      frame_count <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (at_right) begin
        col <= '0;
        if (at_bottom) begin
          row         <= '0;
          frame_count <= frame_count + FRAME_CNT_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Single skid-free output register; payload only changes on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
    end else if (clear) begin
      m_valid <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= {in_center, out_north, out_south, out_east, out_west};
      m_first <= at_top & at_left;
      m_last  <= at_bottom & at_right;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
